// File: rtl/inv_shift_sub_bytes_pkg.sv
// Shared definitions for the AES inverse-round front half.
// Holds the row-major byte layout helpers, the FSM state encoding, the
// legal-lane check and the InvShiftRows permutation.
// No ports (package).
package inv_shift_sub_bytes_pkg;

    localparam int STATE_BYTES = 16;
    localparam int BYTE_W      = 8;
    localparam int STATE_W     = STATE_BYTES * BYTE_W;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Row-major layout: byte k sits at row k/4, column k%4.
    function automatic int byte_idx(input int row, input int col);
        return 4 * row + col;
    endfunction

    // Lane counts must divide the 16-byte state evenly into chunks.
    function automatic bit lanes_ok(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
               (lanes == 8) || (lanes == 16);
    endfunction

    // out[r][c] = in[r][(c-r) mod 4]: row r rotates right by r bytes.
    function automatic logic [0:STATE_W-1] inv_shift_rows(input logic [0:STATE_W-1] s);
        logic [0:STATE_W-1] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[BYTE_W*byte_idx(r, c) +: BYTE_W] =
                    s[BYTE_W*byte_idx(r, (c - r + 4) % 4) +: BYTE_W];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/inv_shift_sub_bytes_if.sv
// Block-level handshake bundle for inv_shift_sub_bytes.
// Input side:  i_valid / o_ready / i_data  (block offered by upstream).
// Output side: o_valid / i_ready / o_data  (result offered downstream).
// fsm_state mirrors the block's FSM for observation.
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1; the offering side holds valid and data
// stable until that edge, and ready carries no meaning while valid is 0.
// slave modport: the block itself; master modport: the environment.
interface inv_shift_sub_bytes_if;
    import inv_shift_sub_bytes_pkg::*;

    logic               i_valid;
    logic               o_ready;
    logic [0:STATE_W-1] i_data;
    logic               o_valid;
    logic               i_ready;
    logic [0:STATE_W-1] o_data;
    state_t             fsm_state;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, fsm_state
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, fsm_state
    );

endinterface

// File: rtl/inv_shift_sub_bytes_inv_sbox.sv
// inv_sbox: combinational FIPS-197 inverse S-box, one byte in, one byte out.
// Ports: data (input byte), result (substituted byte).
module inv_sbox (
    input  logic [7:0] data,
    output logic [7:0] result
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign result = INV_SBOX[data];

endmodule

// File: rtl/inv_shift_sub_bytes.sv
// inv_shift_sub_bytes: InvShiftRows followed by byte-serial InvSubBytes on
// one 128-bit AES state, LANES bytes substituted per cycle.
// Ports:
//   i_clock    rising-edge clock
//   i_reset_n  asynchronous active-low reset
//   bus        handshake bundle (slave side): block in, result out, FSM state
// The permutation is applied while loading, so BUSY only substitutes bytes
// in place; o_data is the state register itself.
module inv_shift_sub_bytes
    import inv_shift_sub_bytes_pkg::*;
#(
    parameter int LANES = 4
) (
    input logic                  i_clock,
    input logic                  i_reset_n,
    inv_shift_sub_bytes_if.slave bus
);

    localparam int CHUNKS = STATE_BYTES / LANES;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

    generate
        if (!lanes_ok(LANES)) begin : g_bad_lanes
            $error("inv_shift_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [0:STATE_W-1] data_q, data_d;
    logic [BYTE_W-1:0]  lane_in  [LANES];
    logic [BYTE_W-1:0]  lane_out [LANES];

    // Lane l works on byte cnt*LANES + l of the current chunk.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l] = data_q[BYTE_W*(int'(cnt_q)*LANES + l) +: BYTE_W];
        inv_sbox u_inv_sbox (
            .data   (lane_in[l]),
            .result (lane_out[l])
        );
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        bus.o_ready = 1'b0;
        bus.o_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_valid) begin
                    data_d  = inv_shift_rows(bus.i_data);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[BYTE_W*(int'(cnt_q)*LANES + l) +: BYTE_W] = lane_out[l];
                end
                // Counter holds on the last chunk rather than wrapping.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                bus.o_valid = 1'b1;
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_data    = data_q;
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_inv_shift_sub_bytes.sv
// Self-checking bench for inv_shift_sub_bytes: five instances (LANES = 1, 2,
// 4, 8, 16) share clock and reset; each is driven through its own interface.
// The reference model builds the S-boxes from GF(2^8) arithmetic and applies
// the row rotations directly.
module tb_inv_shift_sub_bytes;

    localparam int N_DUT = 5;

    logic clk;
    logic rst_n;

    logic               valid_in [N_DUT];
    logic [0:127]       data_in  [N_DUT];
    logic               ready_in [N_DUT];
    logic [N_DUT-1:0]   rdy_out;
    logic [N_DUT-1:0]   vld_out;
    logic [0:127]       dout     [N_DUT];

    int errors = 0;
    int checks = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT instances ----------------
    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        inv_shift_sub_bytes_if bus ();
        assign bus.i_valid = valid_in[g];
        assign bus.i_data  = data_in[g];
        assign bus.i_ready = ready_in[g];
        assign rdy_out[g]  = bus.o_ready;
        assign vld_out[g]  = bus.o_valid;
        assign dout[g]     = bus.o_data;

        inv_shift_sub_bytes #(.LANES(1 << g)) dut (
            .i_clock   (clk),
            .i_reset_n (rst_n),
            .bus       (bus)
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic hi;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [0:127] m_shift(input logic [0:127] s, input bit inverse);
        logic [0:127] o;
        int src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = inverse ? (c - r + 4) % 4 : (c + r) % 4;
                o[8*(4*r + c) +: 8] = s[8*(4*r + src) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] m_sub(input logic [0:127] s, input bit inverse);
        logic [0:127] o;
        logic [7:0] b;
        for (int k = 0; k < 16; k++) begin
            b = s[8*k +: 8];
            o[8*k +: 8] = inverse ? inv_tab[b] : fwd_tab[b];
        end
        return o;
    endfunction

    function automatic logic [0:127] ref_inv(input logic [0:127] s);
        return m_sub(m_shift(s, 1'b1), 1'b1);
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Offers one block, waits (bounded) for the result and completes the
    // output handshake with whatever ready_in currently is (normally 1).
    task automatic run_block(input int g, input logic [0:127] din, input bit scramble,
                             output int lat, output logic [0:127] res);
        int n;
        n = 0;
        while (!rdy_out[g] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        valid_in[g] = 1'b1;
        data_in[g]  = din;
        @(posedge clk); #1;
        valid_in[g] = 1'b0;
        n = 0;
        do begin
            if (scramble) data_in[g] = rand128();
            @(posedge clk); #1;
            n++;
        end while (!vld_out[g] && n < 64);
        lat = n;
        res = dout[g];
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    localparam logic [0:127] RAMP     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] RAMP_EXP = 128'h52096ad5383036a5a39ebf40f3d7fb81;

    initial begin
        int lat;
        logic [0:127] res, snap, blk2, orig;
        logic [7:0] ginv;

        // Build S-boxes from field inverse plus affine map.
        for (int x = 0; x < 256; x++) begin
            ginv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) ginv = 8'(y);
            end
            fwd_tab[x] = ginv ^ rotl8(ginv, 1) ^ rotl8(ginv, 2) ^ rotl8(ginv, 3)
                         ^ rotl8(ginv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

        rst_n = 1'b0;
        for (int g = 0; g < N_DUT; g++) begin
            valid_in[g] = 1'b0;
            data_in[g]  = '0;
            ready_in[g] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < N_DUT; g++) begin
            check($sformatf("reset_valid[%0d]", g), 128'(vld_out[g]), 128'd0);
            check($sformatf("reset_ready[%0d]", g), 128'(rdy_out[g]), 128'd1);
            check($sformatf("reset_data[%0d]", g), dout[g], 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Byte ramp, LANES=4.
        run_block(2, RAMP, 1'b0, lat, res);
        check("ramp_latency", 128'(lat), 128'd4);
        check("ramp_data", res, RAMP_EXP);
        check("ramp_model", res, ref_inv(RAMP));
        check("ramp_ready_after_hs", 128'(rdy_out[2]), 128'd1);
        check("ramp_valid_after_hs", 128'(vld_out[2]), 128'd0);

        // Constant states across every lane count.
        for (int g = 0; g < N_DUT; g++) begin
            run_block(g, {16{8'h63}}, 1'b0, lat, res);
            check($sformatf("all63_lat[%0d]", g), 128'(lat), 128'(16 >> g));
            check($sformatf("all63_data[%0d]", g), res, {16{8'h00}});
            run_block(g, {16{8'h00}}, 1'b0, lat, res);
            check($sformatf("all00_lat[%0d]", g), 128'(lat), 128'(16 >> g));
            check($sformatf("all00_data[%0d]", g), res, {16{8'h52}});
        end

        // Backpressure with a second block waiting, LANES=4.
        ready_in[2] = 1'b0;
        orig = rand128();
        run_block(2, orig, 1'b0, lat, res);
        check("bp_lat", 128'(lat), 128'd4);
        check("bp_data", res, ref_inv(orig));
        snap = dout[2];
        blk2 = rand128();
        valid_in[2] = 1'b1;
        data_in[2]  = blk2;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold_valid[%0d]", i), 128'(vld_out[2]), 128'd1);
            check($sformatf("bp_hold_data[%0d]", i), dout[2], snap);
            check($sformatf("bp_hold_ready[%0d]", i), 128'(rdy_out[2]), 128'd0);
            @(posedge clk); #1;
        end
        ready_in[2] = 1'b1;
        check("bp_still_valid", 128'(vld_out[2]), 128'd1);
        @(posedge clk); #1;
        check("bp_idle_ready", 128'(rdy_out[2]), 128'd1);
        check("bp_idle_valid", 128'(vld_out[2]), 128'd0);
        @(posedge clk); #1;
        valid_in[2] = 1'b0;
        check("bp_second_accepted", 128'(rdy_out[2]), 128'd0);
        lat = 0;
        while (!vld_out[2] && lat < 64) begin
            data_in[2] = rand128();
            @(posedge clk); #1;
            lat++;
        end
        check("bp_second_lat", 128'(lat), 128'd4);
        check("bp_second_data", dout[2], ref_inv(blk2));
        @(posedge clk); #1;

        // Input changes after the accept edge have no effect.
        for (int g = 0; g < N_DUT; g++) begin
            orig = rand128();
            run_block(g, orig, 1'b1, lat, res);
            check($sformatf("stable_data[%0d]", g), res, ref_inv(orig));
        end

        // Asynchronous reset in the middle of BUSY, LANES=1.
        valid_in[0] = 1'b1;
        data_in[0]  = rand128();
        @(posedge clk); #1;
        valid_in[0] = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        check("midrst_busy", 128'(rdy_out[0]), 128'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 128'(vld_out[0]), 128'd0);
        check("midrst_ready", 128'(rdy_out[0]), 128'd1);
        check("midrst_data", dout[0], 128'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(0, RAMP, 1'b0, lat, res);
        check("midrst_ramp_lat", 128'(lat), 128'd16);
        check("midrst_ramp_data", res, RAMP_EXP);

        // Round trip: forward ShiftRows + SubBytes, then this block.
        for (int i = 0; i < 1000; i++) begin
            orig = rand128();
            run_block(i % N_DUT, m_sub(m_shift(orig, 1'b0), 1'b0), 1'b0, lat, res);
            check($sformatf("roundtrip[%0d]", i), res, orig);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
